// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding-request instruction fetch stage.
// Issues word-aligned reads to instruction memory and presents each returned word to
// the decoder with a valid/ready handshake. Branch/jump redirects (pcsrc) flush any
// held or in-flight instruction and restart fetching at the redirect target.
//
// Latency: an ack produces inst_valid one edge later. A decoder accept produces the
// next imem_req one edge later.
// Backpressure: while inst_ready=0 the instruction is held and no new fetch is issued.
//
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   imem_req/imem_addr    read request and word-aligned address (registered)
//   imem_ack/imem_rdata   read completion, data valid in the ack cycle
//   inst_valid/inst_ready instruction handshake towards the decoder
//   op_value/inst_pc      held instruction word and its address (registered)
//   pcsrc/pc_target       redirect request and target (low two bits ignored)

module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] op_value,
  output logic [31:0] inst_pc,
  input  logic        pcsrc,
  input  logic [31:0] pc_target
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  // FETCH: request outstanding, result will be delivered.
  // HOLD : instruction presented to the decoder, no request outstanding.
  // FLUSH: request outstanding, but its result is stale and will be dropped.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] fetch_addr, fetch_addr_n;
  logic [31:0] next_pc, next_pc_n;
  logic        req_q, req_n;
  logic        valid_q, valid_n;
  logic [31:0] op_q, op_n;
  logic [31:0] pc_q, pc_n;

  logic [31:0] target;
  logic        xfer;

  // Targets are forced onto a word boundary.
  assign target = {pc_target[31:2], 2'b00};
  // A transfer completes only when a request is actually outstanding.
  assign xfer   = req_q & imem_ack;

  always_comb begin
    state_n      = state;
    fetch_addr_n = fetch_addr;
    next_pc_n    = next_pc;
    req_n        = req_q;
    valid_n      = valid_q;
    op_n         = op_q;
    pc_n         = pc_q;

    case (state)
      S_FETCH: begin
        if (pcsrc) begin
          if (xfer) begin
            // Returned word belongs to the abandoned path: drop it and
            // immediately request the target.
            fetch_addr_n = target;
            next_pc_n    = target;
            req_n        = 1'b1;
            state_n      = S_FETCH;
          end else begin
            // Address must stay stable until the pending read completes,
            // so remember the target and drain the stale read first.
            next_pc_n = target;
            state_n   = S_FLUSH;
          end
        end else if (xfer) begin
          op_n      = imem_rdata;
          pc_n      = fetch_addr;
          valid_n   = 1'b1;
          req_n     = 1'b0;
          next_pc_n = fetch_addr + 32'd4; // wraps modulo 2^32
          state_n   = S_HOLD;
        end
      end

      S_HOLD: begin
        if (pcsrc) begin
          // Redirect wins over a same-cycle accept: the held word is on
          // the wrong path and must not be considered consumed.
          valid_n      = 1'b0;
          fetch_addr_n = target;
          next_pc_n    = target;
          req_n        = 1'b1;
          state_n      = S_FETCH;
        end else if (valid_q && inst_ready) begin
          valid_n      = 1'b0;
          fetch_addr_n = next_pc;
          req_n        = 1'b1;
          state_n      = S_FETCH;
        end
      end

      S_FLUSH: begin
        valid_n = 1'b0;
        if (pcsrc) begin
          // Latest redirect wins. If the stale read also completes now,
          // there is nothing left to drain, so go straight to the target
          // instead of re-reading the stale address.
          next_pc_n = target;
          if (xfer) begin
            fetch_addr_n = target;
            req_n        = 1'b1;
            state_n      = S_FETCH;
          end
        end else if (xfer) begin
          fetch_addr_n = next_pc;
          req_n        = 1'b1;
          state_n      = S_FETCH;
        end
      end

      default: begin
        state_n = S_FETCH;
        req_n   = 1'b1;
        valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      fetch_addr <= RESET_PC;
      next_pc    <= RESET_PC;
      req_q      <= 1'b1;
      valid_q    <= 1'b0;
      op_q       <= NOP;
      pc_q       <= RESET_PC;
    end else begin
      state      <= state_n;
      fetch_addr <= fetch_addr_n;
      next_pc    <= next_pc_n;
      req_q      <= req_n;
      valid_q    <= valid_n;
      op_q       <= op_n;
      pc_q       <= pc_n;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = fetch_addr;
  assign inst_valid = valid_q;
  assign op_value   = op_q;
  assign inst_pc    = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed vectors for instr_fetch, one instance at RESET_PC=0 and
// one at RESET_PC=32'hFFFF_FFFC sharing all inputs.
// Expected values are hand-computed per step; outputs are sampled 1 time unit after
// each rising edge.

module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_ready;
  logic        pcsrc;
  logic [31:0] pc_target;

  logic        imem_req, inst_valid;
  logic [31:0] imem_addr, op_value, inst_pc;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_op, w_pc;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .op_value(op_value), .inst_pc(inst_pc),
    .pcsrc(pcsrc), .pc_target(pc_target)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(w_valid), .inst_ready(inst_ready),
    .op_value(w_op), .inst_pc(w_pc),
    .pcsrc(pcsrc), .pc_target(pc_target)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic [31:0] d, input logic r,
                       input logic p, input logic [31:0] t);
    imem_ack   = a;
    imem_rdata = d;
    inst_ready = r;
    pcsrc      = p;
    pc_target  = t;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Reset state
    step();
    chk("rst_req",   {31'd0, imem_req},   32'd1);
    chk("rst_addr",  imem_addr,           32'h0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_op",    op_value,            32'h0000_0013);
    chk("rst_pc",    inst_pc,             32'h0);
    chk("rst_waddr", w_addr,              32'hFFFF_FFFC);
    rst = 1'b0;

    // Basic fetch: ack two cycles after reset release
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step();
    chk("f0_addr", imem_addr, 32'h0);
    chk("f0_req",  {31'd0, imem_req}, 32'd1);
    drive(1'b1, 32'h0050_0093, 1'b1, 1'b0, 32'h0);
    step();
    chk("f0_valid", {31'd0, inst_valid}, 32'd1);
    chk("f0_op",    op_value,            32'h0050_0093);
    chk("f0_pc",    inst_pc,             32'h0);
    chk("f0_req0",  {31'd0, imem_req},   32'd0);
    chk("wrap_pc",  w_pc,                32'hFFFF_FFFC);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step();
    chk("f1_addr",   imem_addr,           32'h4);
    chk("f1_req",    {31'd0, imem_req},   32'd1);
    chk("f1_valid",  {31'd0, inst_valid}, 32'd0);
    chk("wrap_addr", w_addr,              32'h0);

    // Back-pressure in HOLD
    drive(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
    step();
    chk("bp_valid", {31'd0, inst_valid}, 32'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_op",    op_value,            32'h1234_5678);
      chk("bp_hold_pc",    inst_pc,             32'h4);
      chk("bp_hold_valid", {31'd0, inst_valid}, 32'd1);
      chk("bp_hold_req",   {31'd0, imem_req},   32'd0);
    end
    inst_ready = 1'b1;
    step();
    chk("bp_rel_addr",  imem_addr,           32'h8);
    chk("bp_rel_req",   {31'd0, imem_req},   32'd1);
    chk("bp_rel_valid", {31'd0, inst_valid}, 32'd0);

    // Redirect while waiting for ack -> FLUSH
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0103);
    step();
    chk("fl_addr",  imem_addr,           32'h8);
    chk("fl_req",   {31'd0, imem_req},   32'd1);
    chk("fl_valid", {31'd0, inst_valid}, 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    chk("fl_hold_addr", imem_addr, 32'h8);
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    step();
    chk("fl_ack_addr",  imem_addr,           32'h100);
    chk("fl_ack_valid", {31'd0, inst_valid}, 32'd0);
    chk("fl_ack_req",   {31'd0, imem_req},   32'd1);
    chk("fl_ack_op",    op_value,            32'h1234_5678);

    // Coincident ack + redirect in FETCH
    drive(1'b1, 32'hBAD0_0001, 1'b0, 1'b1, 32'h0000_0040);
    step();
    chk("co_valid", {31'd0, inst_valid}, 32'd0);
    chk("co_addr",  imem_addr,           32'h40);
    chk("co_req",   {31'd0, imem_req},   32'd1);
    drive(1'b1, 32'h0011_0113, 1'b0, 1'b0, 32'h0);
    step();
    chk("co_t_valid", {31'd0, inst_valid}, 32'd1);
    chk("co_t_pc",    inst_pc,             32'h40);
    chk("co_t_op",    op_value,            32'h0011_0113);

    // Redirect + accept together in HOLD
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0202);
    step();
    chk("hr_valid", {31'd0, inst_valid}, 32'd0);
    chk("hr_addr",  imem_addr,           32'h200);
    chk("hr_req",   {31'd0, imem_req},   32'd1);

    // Two redirects in a row: latest target wins
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0300);
    step();
    chk("lw_addr0", imem_addr, 32'h200);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0404);
    step();
    chk("lw_addr1", imem_addr, 32'h200);
    drive(1'b1, 32'hBAD0_0002, 1'b0, 1'b0, 32'h0);
    step();
    chk("lw_addr2",  imem_addr,           32'h404);
    chk("lw_valid",  {31'd0, inst_valid}, 32'd0);

    // Reset while in FLUSH
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0500);
    step();
    rst = 1'b1;
    drive(1'b1, 32'hBAD0_0003, 1'b1, 1'b1, 32'h0000_0600);
    step();
    chk("rf_req",   {31'd0, imem_req},   32'd1);
    chk("rf_addr",  imem_addr,           32'h0);
    chk("rf_valid", {31'd0, inst_valid}, 32'd0);
    chk("rf_op",    op_value,            32'h0000_0013);
    chk("rf_waddr", w_addr,              32'hFFFF_FFFC);
    rst = 1'b0;

    // Reset while in HOLD
    drive(1'b1, 32'h00A0_0A13, 1'b0, 1'b0, 32'h0);
    step();
    chk("rh_pre_valid", {31'd0, inst_valid}, 32'd1);
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    chk("rh_req",   {31'd0, imem_req},   32'd1);
    chk("rh_addr",  imem_addr,           32'h0);
    chk("rh_valid", {31'd0, inst_valid}, 32'd0);
    chk("rh_op",    op_value,            32'h0000_0013);
    chk("rh_pc",    inst_pc,             32'h0);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 imem_req  output  1  instruction-memory read request.
REQ-005 imem_addr  output  32  word-aligned read address.
REQ-006 imem_ack  input  1  read complete; imem_rdata valid in the same cycle.
REQ-007 imem_rdata  input  32  instruction word from memory.
REQ-008 inst_valid  output  1  op_value/inst_pc hold an instruction for the decoder.
REQ-009 inst_ready  input  1  decoder accepts the held instruction.
REQ-010 op_value  output  32  instruction word to the decoder.
REQ-011 inst_pc  output  32  address of the instruction in op_value.
REQ-012 pcsrc  input  1  redirect: 1 = branch or jump to pc_target; 0 = sequential (+4).
REQ-013 pc_target  input  32  redirect address, sampled only when pcsrc=1.

Function
REQ-014 The block SHALL implement FSM states FETCH (request outstanding), HOLD (instruction held) and FLUSH (request outstanding, data to be discarded).
REQ-015 Registers SHALL be fetch_addr (drives imem_addr) and next_pc (next fetch address); all outputs SHALL be registered.
REQ-016 A memory transfer SHALL complete at the edge where imem_req=1 and imem_ack=1; imem_addr SHALL stay stable while imem_req=1 and no transfer has occurred.
REQ-017 FETCH, on ack with pcsrc=0: op_value<=imem_rdata, inst_pc<=fetch_addr, inst_valid<=1, imem_req<=0, next_pc<=fetch_addr+4, go to HOLD.
REQ-018 HOLD, on inst_valid=1 and inst_ready=1 with pcsrc=0: inst_valid<=0, imem_req<=1, fetch_addr<=next_pc, go to FETCH; ack-to-valid latency 1 edge; accept-to-request latency 1 edge.
REQ-019 HOLD, with inst_ready=0: op_value, inst_pc and inst_valid SHALL hold.
REQ-020 Redirect: pc_target[1:0] SHALL be forced to 2'b00; pcsrc SHALL take priority over inst_ready and imem_ack.
REQ-021 Redirect in HOLD: inst_valid<=0 (held instruction flushed, even if inst_ready=1 in the same cycle), fetch_addr<=target, imem_req<=1, go to FETCH.
REQ-022 Redirect in FETCH with imem_ack=1 in the same cycle: discard imem_rdata, fetch_addr<=target, imem_req stays 1, stay in FETCH.
REQ-023 Redirect in FETCH with imem_ack=0: next_pc<=target, keep imem_req and fetch_addr unchanged, go to FLUSH.
REQ-024 FLUSH, on ack: discard imem_rdata, fetch_addr<=next_pc, stay requesting, go to FETCH; inst_valid SHALL remain 0 throughout FLUSH.
REQ-025 Redirect in FLUSH: next_pc<=new target (latest redirect wins), remain in FLUSH.
REQ-026 Address arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC+4 = 32'h0000_0000.
REQ-027 An instruction SHALL reach op_value only from an ack received in FETCH without a coincident redirect.

Reset
REQ-028 While rst=1 at an edge: state<=FETCH, fetch_addr<=RESET_PC, next_pc<=RESET_PC, imem_req<=1, inst_valid<=0, op_value<=32'h0000_0013 (NOP), inst_pc<=RESET_PC.
REQ-029 Reset SHALL override all inputs, abandon any outstanding request or held instruction, and take effect at the first edge where rst=1; the memory SHALL be reset by the same rst.

Verification
REQ-030 Reset, then imem_ack=1 with rdata=32'h00500093 two cycles after reset release, inst_ready=1 -> imem_addr=0, next cycle inst_valid=1 with op_value=32'h00500093 and inst_pc=0, then imem_addr=4.
REQ-031 Back-pressure: inst_ready=0 for 5 cycles in HOLD -> op_value and inst_pc stable, imem_req=0, no new fetch until inst_ready=1.
REQ-032 Redirect while waiting for ack (pcsrc=1, pc_target=32'h0000_0103 at addr 8) -> FLUSH, addr 8 held until ack, data discarded, next imem_addr=32'h0000_0100, inst_valid never 1 for addr 8.
REQ-033 Coincident ack and pcsrc in FETCH (target 32'h40) -> no inst_valid; next request at 32'h40; also pcsrc and inst_ready together in HOLD -> instruction flushed, fetch at target.
REQ-034 Wrap-around: RESET_PC=32'hFFFF_FFFC, one accepted instruction -> next imem_addr=32'h0000_0000.
REQ-035 rst asserted in FLUSH and in HOLD -> next cycle imem_req=1, imem_addr=RESET_PC, inst_valid=0, op_value=32'h0000_0013.
